// File: rtl/word_serializer_pkg.sv
// rtl/word_serializer_pkg.sv - shared types and sizing helpers for word_serializer
// Purpose: shifter FSM state type, frame length and bit counter width.
// Ports: none (package).
// Configuration: `define WORD_SERIALIZER_PARITY_EN appends one even-parity bit per frame.
package word_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bits emitted per accepted word, including the optional parity bit.
  function automatic int frame_len(input int data_w);
`ifdef WORD_SERIALIZER_PARITY_EN
    return data_w + 1;
`else
    return data_w;
`endif
  endfunction

  // Counter only has to reach frame_len-1; keep at least one bit.
  function automatic int cnt_width(input int flen);
    return (flen <= 2) ? 1 : $clog2(flen);
  endfunction

endpackage

// File: rtl/word_serializer_hold.sv
// rtl/word_serializer_hold.sv - one-entry holding register with full flag
// Purpose: parks the next word while the shifter is still busy with the current one.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load, i_data : capture i_data and mark full
//   i_take         : release the entry (shifter has taken it)
//   o_full, o_data : occupancy flag and stored word
module word_serializer_hold #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_take,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic [W-1:0] o_data
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // Load and take never coincide: the writer only loads while the entry is empty.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (i_load) begin
      full_d = 1'b1;
      data_d = i_data;
    end else if (i_take) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign o_full = full_q;
  assign o_data = data_q;

endmodule

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - parallel-to-serial stage feeding the bit scrambler
// Purpose: accepts DATA_W-bit words on valid/ready and emits one bit per enabled
//          cycle on (o_data, o_dv); a holding register keeps back-to-back words gapless.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_data, i_valid  : parallel word and its valid
//   o_ready          : a word can be accepted this cycle (hold register empty)
//   i_en             : downstream enable; 0 freezes emission and frame position
//   o_data, o_dv     : registered serial bit and its valid
//   o_busy           : shifter or hold register occupied
// Configuration: `define WORD_SERIALIZER_PARITY_EN emits an even-parity bit after each word.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_en,
  output logic              o_data,
  output logic              o_dv,
  output logic              o_busy
);

  localparam int FRAME_LEN = frame_len(DATA_W);
  localparam int CNT_W     = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [FRAME_LEN-1:0]   frame_q;
  logic                   data_q;
  logic                   dv_q;

  logic                   hold_full;
  logic [DATA_W-1:0]      hold_data;
  logic                   accept;
  logic                   last_edge;
  logic                   hold_load;
  logic                   hold_take;
  logic [DATA_W-1:0]      word_sel;
  logic [DATA_W-1:0]      word_ord;
  logic [FRAME_LEN-1:0]   frame_new;

  // Reset gates ready so nothing can be handshaken while the block is held.
  assign o_ready   = i_rst_n & ~hold_full;
  assign accept    = i_valid & o_ready;
  assign last_edge = (state_q == SHIFT) & i_en & (cnt_q == CNT_LAST);
  assign hold_load = accept & (state_q == SHIFT) & ~last_edge;
  assign hold_take = last_edge & hold_full;

  // A pending hold entry always wins the shifter; otherwise the incoming word bypasses hold.
  assign word_sel = hold_full ? hold_data : i_data;

  // The frame is stored in transmit order so the shifter always emits bit 0.
  always_comb begin
    word_ord = '0;
    for (int i = 0; i < DATA_W; i++) begin
      word_ord[i] = LSB_FIRST ? word_sel[i] : word_sel[DATA_W-1-i];
    end
  end

`ifdef WORD_SERIALIZER_PARITY_EN
  assign frame_new = {^word_sel, word_ord};
`else
  assign frame_new = word_ord;
`endif

  word_serializer_hold #(
    .W (DATA_W)
  ) u_hold (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (hold_load),
    .i_take  (hold_take),
    .i_data  (i_data),
    .o_full  (hold_full),
    .o_data  (hold_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      data_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          dv_q <= 1'b0;
          if (accept) begin
            frame_q <= frame_new;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (i_en) begin
            data_q <= frame_q[0];
            dv_q   <= 1'b1;
            if (cnt_q == CNT_LAST) begin
              // Reload on the last-bit edge keeps o_dv continuous across words.
              if (hold_full || accept) begin
                frame_q <= frame_new;
                cnt_q   <= '0;
              end else begin
                cnt_q   <= '0;
                state_q <= IDLE;
              end
            end else begin
              frame_q <= frame_q >> 1;
              cnt_q   <= cnt_q + 1'b1;
            end
          end else begin
            dv_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_data = data_q;
  assign o_dv   = dv_q;
  assign o_busy = (state_q == SHIFT) | hold_full;

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - self-checking bench for word_serializer (LSB- and MSB-first instances)
module tb_word_serializer;

  localparam int W = 8;
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int FL  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = W;
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] data = '0;
  logic         l_data, l_dv, l_ready, l_busy;
  logic         m_data, m_dv, m_ready, m_busy;

  always #5 clk = ~clk;

  word_serializer #(.DATA_W(W), .LSB_FIRST(1'b1)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(l_ready),
    .i_en(en), .o_data(l_data), .o_dv(l_dv), .o_busy(l_busy)
  );

  word_serializer #(.DATA_W(W), .LSB_FIRST(1'b0)) u_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(m_ready),
    .i_en(en), .o_data(m_data), .o_dv(m_dv), .o_busy(m_busy)
  );

  int   n_total = 0;
  int   n_bad   = 0;
  bit   q_l[$];
  bit   q_m[$];
  logic exp_dv = 1'b0;
  logic exp_l  = 1'b0;
  logic exp_m  = 1'b0;
  bit   acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Words still owed to the output (in flight or waiting); the block holds at most two.
  function automatic bit model_ready();
    return ((q_l.size() + FL - 1) / FL) < 2;
  endfunction

  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      q_l.push_back(d[i]);
      q_m.push_back(d[W-1-i]);
    end
    if (PAR) begin
      q_l.push_back(^d);
      q_m.push_back(^d);
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, "_dv_l"},   l_dv,   exp_dv);
    check({where, "_dv_m"},   m_dv,   exp_dv);
    check({where, "_data_l"}, l_data, exp_l);
    check({where, "_data_m"}, m_data, exp_m);
    check({where, "_busy_l"}, l_busy, q_l.size() != 0);
    check({where, "_busy_m"}, m_busy, q_m.size() != 0);
  endtask

  // One clock: drive inputs, check ready, advance the model across the edge, check outputs.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic e, output bit accepted);
    bit rdy;
    valid = v;
    data  = d;
    en    = e;
    rdy   = model_ready();
    check("ready_l", l_ready, rdy);
    check("ready_m", m_ready, rdy);
    @(posedge clk);
    accepted = v && rdy;
    if (e && q_l.size() > 0) begin
      exp_dv = 1'b1;
      exp_l  = q_l.pop_front();
      exp_m  = q_m.pop_front();
    end else begin
      exp_dv = 1'b0;
    end
    if (accepted) push_word(d);
    #1;
    check_outputs("cyc");
  endtask

  task automatic send(input logic [W-1:0] d, input logic e);
    bit a;
    a = 1'b0;
    for (int t = 0; t < 40 && !a; t++) cycle(1'b1, d, e, a);
    if (!a) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, a);
  endtask

  task automatic reset_checks(input string where);
    check({where, "_ready_l"}, l_ready, 1'b0);
    check({where, "_ready_m"}, m_ready, 1'b0);
    check({where, "_dv_l"},    l_dv,    1'b0);
    check({where, "_dv_m"},    m_dv,    1'b0);
    check({where, "_data_l"},  l_data,  1'b0);
    check({where, "_data_m"},  m_data,  1'b0);
    check({where, "_busy_l"},  l_busy,  1'b0);
    check({where, "_busy_m"},  m_busy,  1'b0);
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    #2 rst_n = 1'b1;
    #1;
    check("rel_ready_l", l_ready, 1'b1);
    check("rel_ready_m", m_ready, 1'b1);
    idle(2);

    // Single word
    send(8'hA5, 1'b1);
    idle(FL + 2);

    // Back-to-back through the hold register
    send(8'h01, 1'b1);
    send(8'h80, 1'b1);
    send(8'hFF, 1'b1);
    idle(3 * FL + 2);

    // Throttle after bit 3
    send(8'hA5, 1'b1);
    idle(4);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, acc);
    idle(FL + 2);

    // Reset mid-word, then a clean word
    send(8'hA5, 1'b1);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("mid_rst");
    q_l.delete();
    q_m.delete();
    exp_dv = 1'b0;
    exp_l  = 1'b0;
    exp_m  = 1'b0;
    @(posedge clk);
    #1;
    reset_checks("mid_rst_hold");
    #2 rst_n = 1'b1;
    #1;
    check("mid_rel_ready", l_ready, 1'b1);
    send(8'h3C, 1'b1);
    idle(FL + 2);

    // Parity-sensitive words (plain serialization when parity is off)
    send(8'h07, 1'b1);
    idle(FL + 1);
    send(8'h03, 1'b1);
    idle(FL + 1);

    // Randomized traffic and throttling
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0), acc);
    end
    idle(3 * FL);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-to-serial stage directly upstream of the bit-level scrambler: accepts DATA_W-bit words on a valid/ready handshake and emits one bit per enabled cycle as an (o_data, o_dv) stream, which connects straight to the scrambler's (i_data, i_dv).
- A one-word holding register allows back-to-back words to serialize with no idle gap.
- A downstream enable (i_en) throttles bit emission.

Parameters:
- DATA_W, 8: input word width in bits; must be >= 2.
- LSB_FIRST, 1: 1 = bit 0 is transmitted first; 0 = bit DATA_W-1 is transmitted first.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_data  in  DATA_W  parallel word, sampled on accept.
- i_valid  in  1  i_data is valid.
- o_ready  out  1  block can accept a word this cycle.
- i_en  in  1  downstream enable; when 0, no bit is emitted and the frame position is frozen.
- o_data  out  1  serial bit, registered.
- o_dv  out  1  o_data is valid this cycle, registered.
- o_busy  out  1  shifter or holding register occupied.

Behaviour:
- Reset values: o_data=0, o_dv=0, o_busy=0, shifter empty, hold empty, bit counter=0. o_ready is forced 0 while i_rst_n=0.
- Assertion of i_rst_n=0 mid-word discards all state immediately. No partial frame resumes after release.
- Accept: a word is accepted on the rising edge where i_valid=1 and o_ready=1.
- o_ready = !hold_full. It is combinational from registered state only, with no path from i_valid.
- Shifter FSM, IDLE:
  - Shifter empty.
  - On accept, the word loads directly into the shifter (hold bypassed); bit counter=0; go to SHIFT.
- Shifter FSM, SHIFT:
  - Each edge with i_en=1: o_data <= current bit (index cnt if LSB_FIRST, else DATA_W-1-cnt); o_dv <= 1; cnt increments.
  - Each edge with i_en=0: o_dv <= 0; o_data holds; cnt holds.
- Last bit (cnt=FRAME_LEN-1 emitted with i_en=1), same edge:
  - If hold is full, load the shifter from hold, clear hold, cnt=0, stay in SHIFT.
  - Else, if an accept occurs on that edge, load the accepted word directly into the shifter.
  - Else go to IDLE.
- Accept while in SHIFT and not on the last-bit edge: the word goes to hold.
- Simultaneous hold→shifter transfer and new accept: cannot occur, because o_ready=0 whenever hold is full.
- Latency: word accepted at edge k with the block idle and i_en=1 → first bit has o_dv=1 in the cycle after edge k+1. Each subsequent bit follows one enabled cycle later.
- Throughput: one word per FRAME_LEN enabled cycles; o_dv is continuous across word boundaries when words are supplied in time.
- FRAME_LEN = DATA_W, or DATA_W+1 when parity is enabled.
- Counter width: $clog2(FRAME_LEN).
- Counter reset: the counter returns to 0 on every load; it never wraps past FRAME_LEN-1.
- o_busy = (state==SHIFT) | hold_full.

Optional Feature:
- Macro: WORD_SERIALIZER_PARITY_EN.
- Defined:
  - FRAME_LEN=DATA_W+1.
  - After the last data bit, one even-parity bit (XOR of the DATA_W bits of that word) is emitted, with o_dv=1 and subject to i_en like any other bit.
  - Parity is computed at load time and stored with the shifter.
- Undefined: no parity bit, FRAME_LEN=DATA_W, and no parity logic is synthesized.

Decomposition:
- Package word_serializer_pkg:
  - State enum typedef (IDLE, SHIFT).
  - FRAME_LEN computation as a function of DATA_W and the parity macro.
  - Counter-width function.
- One natural sub-module: word_serializer_hold, a one-entry holding register with full flag, load and take strobes.
- The FSM, shifter and output registers stay in the top module.

Test Plan:
- Reset / idle: i_rst_n low then high with i_valid=0 → o_dv=0, o_data=0, o_busy=0, o_ready=1 after release; o_ready=0 while in reset.
- Single word: DATA_W=8, LSB_FIRST=1, i_en=1, accept 0xA5 at edge k → o_dv=1 for exactly 8 cycles starting after edge k+1, with o_data = 1,0,1,0,0,1,0,1; then o_busy=0.
- Back-to-back with hold: i_valid held with 0x01 then 0x80 then 0xFF → 24 contiguous o_dv cycles, bit order correct. o_ready is low from the second accept until the first word's last-bit edge, and again from the third accept until the second word's last-bit edge.
- Throttle: during 0xA5, drive i_en=0 for 3 cycles after bit 3 → o_dv=0 for those 3 cycles, o_data frozen, then bits 4..7 resume unchanged.
- MSB-first, reset mid-word: LSB_FIRST=0, 0xA5 → 1,0,1,0,0,1,0,1 (MSB first). Assert i_rst_n=0 after bit 2 → o_dv drops at once. After release, 0x3C is serialized from bit 0 with no residue.
- Parity (WORD_SERIALIZER_PARITY_EN): 0x07 → 8 data bits then parity bit 1 (9 o_dv cycles); 0x03 → parity bit 0.
